// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR MAC sequencer slice.
package fir_pkg;

  localparam int TAPS     = 10;
  localparam int SAMPLE_W = 3;
  localparam int ADDR_W   = 4;   // 2**ADDR_W must cover TAPS
  localparam int DELAY_W  = TAPS * SAMPLE_W;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LAST,
    DONE
  } seqState_t;

endpackage

// File: rtl/fir_mac_seq_if.sv
// Sample input, delay-chain, coefficient SRAM and MAC control bundle of the
// FIR MAC sequencer. Optional macro FIR_SAMPLE_OVF_EN adds iOvfClr/oOvf.
// The sequencer attaches through modport master; the environment through slave.
interface fir_mac_seq_if;
  import fir_pkg::*;

  logic                iEnSample;
  logic [SAMPLE_W-1:0] iFirIn;
  logic [DELAY_W-1:0]  oDelay;
  logic                oCsn;
  logic                oWrn;
  logic [ADDR_W-1:0]   oAddr;
  logic                oEnMul;
  logic                oEnAddAcc;
  logic                oBusy;
  logic                oDone;
`ifdef FIR_SAMPLE_OVF_EN
  logic                iOvfClr;
  logic                oOvf;

  modport master (
    input  iEnSample, iFirIn, iOvfClr,
    output oDelay, oCsn, oWrn, oAddr, oEnMul, oEnAddAcc, oBusy, oDone, oOvf
  );

  modport slave (
    output iEnSample, iFirIn, iOvfClr,
    input  oDelay, oCsn, oWrn, oAddr, oEnMul, oEnAddAcc, oBusy, oDone, oOvf
  );
`else
  modport master (
    input  iEnSample, iFirIn,
    output oDelay, oCsn, oWrn, oAddr, oEnMul, oEnAddAcc, oBusy, oDone
  );

  modport slave (
    output iEnSample, iFirIn,
    input  oDelay, oCsn, oWrn, oAddr, oEnMul, oEnAddAcc, oBusy, oDone
  );
`endif

endinterface

// File: rtl/fir_delay_line.sv
// Tap delay chain: shifts one sample in at tap 0 on each load, the oldest
// tap falls off the top. Holds otherwise.
module fir_delay_line #(
  parameter int TAPS     = 10,
  parameter int SAMPLE_W = 3
) (
  input  logic                     iClk12M,
  input  logic                     iRsn,
  input  logic                     iLoad,
  input  logic [SAMPLE_W-1:0]      iSample,
  output logic [TAPS*SAMPLE_W-1:0] oTaps
);

  // shift the chain by one tap on an accepted sample
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      oTaps <= '0;
    end else if (iLoad) begin
      oTaps <= {oTaps[(TAPS-1)*SAMPLE_W-1:0], iSample};
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// FIR MAC sequencer: per accepted sample, reads all coefficients from the
// single-port SRAM and drives MAC enables aligned to the read data.
// Optional macro FIR_SAMPLE_OVF_EN adds a sticky dropped-sample flag.
//
// state | meaning
// IDLE  | waiting for a sample strobe
// READ  | coefficient reads in flight, oAddr walks 0..TAPS-1
// LAST  | SRAM deselected, final MAC enable cycle
// DONE  | oDone high; a new strobe here starts the next sequence directly
module fir_mac_seq
  import fir_pkg::*;
(
  input  logic          iClk12M,
  input  logic          iRsn,
  fir_mac_seq_if.master bus
);

  seqState_t         state;
  logic              accept;
  logic              csn;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              done;
  logic              enMac;

  // the DONE cycle still counts as busy, but the sequence has ended, so a
  // strobe there is taken rather than dropped
  assign accept = bus.iEnSample && ((state == IDLE) || (state == DONE));

  fir_delay_line #(
    .TAPS    (TAPS),
    .SAMPLE_W(SAMPLE_W)
  ) uDelayLine (
    .iClk12M(iClk12M),
    .iRsn   (iRsn),
    .iLoad  (accept),
    .iSample(bus.iFirIn),
    .oTaps  (bus.oDelay)
  );

  // sequence FSM: SRAM select, tap counter, busy and done
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state <= IDLE;
      csn   <= 1'b1;
      addr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            csn   <= 1'b0;
            addr  <= '0;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          if (addr == LAST_ADDR) begin
            csn   <= 1'b1;
            addr  <= '0;
            state <= LAST;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        LAST: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (accept) begin
            csn   <= 1'b0;
            addr  <= '0;
            state <= READ;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM data lags the select by one cycle, so the MAC enables do too
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      enMac <= 1'b0;
    end else begin
      enMac <= !csn;
    end
  end

  assign bus.oCsn      = csn;
  assign bus.oWrn      = 1'b1;
  assign bus.oAddr     = addr;
  assign bus.oEnMul    = enMac;
  assign bus.oEnAddAcc = enMac;
  assign bus.oBusy     = busy;
  assign bus.oDone     = done;

`ifdef FIR_SAMPLE_OVF_EN
  logic dropped;
  logic ovf;

  assign dropped = bus.iEnSample && ((state == READ) || (state == LAST));

  // sticky dropped-sample flag; a new drop beats a simultaneous clear
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      ovf <= 1'b0;
    end else if (dropped) begin
      ovf <= 1'b1;
    end else if (bus.iOvfClr) begin
      ovf <= 1'b0;
    end
  end

  assign bus.oOvf = ovf;
`endif

endmodule
